// File: rtl/ext_edge_counter_multi.sv
// ---------------------------------------------------------------------------
// ext_edge_counter_multi
//
// Counts edges on a set of external pins. Everything runs in the CLK_IN
// domain: the pins are only ever sampled as data and never used as clocks.
// Each channel has the same pipeline:
//
//   sig_i[n] -> synchroniser -> optional glitch filter -> prev-level edge
//   detector -> counter (wrap or saturate) with a sticky overflow flag
//
// One channel's counter top byte is registered onto disp_o for board LEDs.
//
// Ports:
//   CLK_IN        system clock; all logic on posedge
//   RST_IN        asynchronous, active-high reset
//   sig_i         raw external inputs, asynchronous to CLK_IN
//   edge_mode_i   00 disabled, 01 rising, 10 falling, 11 both edges
//   clear_i       synchronous per-channel clear of counter and overflow
//   sel_i         channel whose counter top byte is shown on disp_o
//   disp_o        registered counter[sel_i][CNT_WIDTH-1 -: 8]; 0 if out of range
//   edge_pulse_o  one-cycle pulse for every counted edge
//   overflow_o    sticky overflow per channel
//   count_flat_o  all counters; channel n at [n*CNT_WIDTH +: CNT_WIDTH]
//
// Latency: a level first sampled at edge k shows up in the counter and in
// edge_pulse_o after edge k + SYNC_STAGES + FILTER_LEN.
//
// Note: releasing reset while a pin is already high counts one rising edge
// on that channel once the pipeline fills, because prev starts at 0.
// ---------------------------------------------------------------------------
module ext_edge_counter_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0,
    parameter int SATURATE    = 0,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          CLK_IN,
    input  logic                          RST_IN,
    input  logic [CHANNELS-1:0]           sig_i,
    input  logic [1:0]                    edge_mode_i,
    input  logic [CHANNELS-1:0]           clear_i,
    input  logic [SEL_W-1:0]              sel_i,
    output logic [7:0]                    disp_o,
    output logic [CHANNELS-1:0]           edge_pulse_o,
    output logic [CHANNELS-1:0]           overflow_o,
    output logic [CHANNELS*CNT_WIDTH-1:0] count_flat_o
);

    // Top byte of every counter, padded out to the full sel_i range so that
    // selecting a channel that does not exist reads back zero.
    logic [7:0] top_byte [2**SEL_W];

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_lvl;
        logic                   filt_lvl;
        logic                   prev_q;
        logic                   rise;
        logic                   fall;
        logic                   hit;
        logic [CNT_WIDTH-1:0]   cnt_q;
        logic                   ovf_q;
        logic                   pulse_q;

        // -------------------------------------------------------------------
        // Synchroniser: sync_q[0] takes the raw pin, only the last stage is
        // used downstream.
        // -------------------------------------------------------------------
        always_ff @(posedge CLK_IN or posedge RST_IN) begin
            if (RST_IN) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i[n]};
            end
        end

        assign sync_lvl = sync_q[SYNC_STAGES-1];

        // -------------------------------------------------------------------
        // Glitch filter. The filtered level follows the synchronised level
        // only once the two have differed for FILTER_LEN consecutive cycles.
        // Any cycle where they agree again throws the run away.
        // -------------------------------------------------------------------
        if (FILTER_LEN > 0) begin : g_filt
            localparam int RUN_W = $clog2(FILTER_LEN + 1);
            localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

            logic [RUN_W-1:0] run_q;
            logic             filt_q;

            always_ff @(posedge CLK_IN or posedge RST_IN) begin
                if (RST_IN) begin
                    run_q  <= '0;
                    filt_q <= 1'b0;
                end else if (sync_lvl != filt_q) begin
                    // The FILTER_LEN-th differing cycle commits the new level.
                    if (run_q == RUN_LAST) begin
                        filt_q <= sync_lvl;
                        run_q  <= '0;
                    end else begin
                        run_q <= run_q + 1'b1;
                    end
                end else begin
                    run_q <= '0;
                end
            end

            assign filt_lvl = filt_q;
        end else begin : g_nofilt
            assign filt_lvl = sync_lvl;
        end

        // -------------------------------------------------------------------
        // Edge detect. prev follows the filtered level every cycle, whatever
        // the mode, so changing edge_mode_i can never fabricate an edge.
        // -------------------------------------------------------------------
        assign rise = filt_lvl & ~prev_q;
        assign fall = ~filt_lvl & prev_q;
        assign hit  = (edge_mode_i[0] & rise) | (edge_mode_i[1] & fall);

        // -------------------------------------------------------------------
        // Counter, overflow and pulse. clear_i beats a simultaneous edge but
        // leaves the sync/filter/prev state alone.
        // -------------------------------------------------------------------
        always_ff @(posedge CLK_IN or posedge RST_IN) begin
            if (RST_IN) begin
                prev_q  <= 1'b0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                prev_q <= filt_lvl;
                if (clear_i[n]) begin
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    pulse_q <= 1'b0;
                end else if (hit) begin
                    pulse_q <= 1'b1;
                    if (&cnt_q) begin
                        // At max: saturating counters hold, wrapping ones
                        // roll to zero. Both flag the overflow.
                        ovf_q <= 1'b1;
                        if (SATURATE == 0) begin
                            cnt_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    pulse_q <= 1'b0;
                end
            end
        end

        assign count_flat_o[n*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign edge_pulse_o[n]                        = pulse_q;
        assign overflow_o[n]                          = ovf_q;
        assign top_byte[n]                            = cnt_q[CNT_WIDTH-1 -: 8];
    end

    for (genvar i = CHANNELS; i < 2**SEL_W; i++) begin : g_pad
        assign top_byte[i] = 8'h00;
    end

    // -----------------------------------------------------------------------
    // Display register: one cycle behind sel_i and behind the counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            disp_o <= 8'h00;
        end else begin
            disp_o <= top_byte[sel_i];
        end
    end

endmodule

// File: tb/tb_ext_edge_counter_multi.sv
// ---------------------------------------------------------------------------
// Bench for ext_edge_counter_multi. Three instances cover the parameter
// corners: defaults (u_dut), a 3-cycle filter with 8-bit wrapping counters
// and a non-power-of-two channel count (u_filt), and an 8-bit saturating
// single channel (u_sat). Inputs change on the falling clock edge, outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ext_edge_counter_multi;

    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int FCH = 3;
    localparam int FCW = 8;

    // ---------------- clock / reset ----------------
    logic CLK_IN = 1'b0;
    logic RST_IN;
    always #5 CLK_IN = ~CLK_IN;

    int unsigned cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    // ---------------- default instance ----------------
    logic [CH-1:0]    sig;
    logic [CH-1:0]    clr;
    logic [1:0]       mode;
    logic [1:0]       sel;
    logic [7:0]       disp;
    logic [CH-1:0]    epulse;
    logic [CH-1:0]    ovf;
    logic [CH*CW-1:0] flat;

    ext_edge_counter_multi u_dut (
        .CLK_IN       (CLK_IN),
        .RST_IN       (RST_IN),
        .sig_i        (sig),
        .edge_mode_i  (mode),
        .clear_i      (clr),
        .sel_i        (sel),
        .disp_o       (disp),
        .edge_pulse_o (epulse),
        .overflow_o   (ovf),
        .count_flat_o (flat)
    );

    // ---------------- filtered, 8-bit wrap, 3 channels ----------------
    logic [FCH-1:0]     f_sig;
    logic [FCH-1:0]     f_clr;
    logic [1:0]         f_mode;
    logic [1:0]         f_sel;
    logic [7:0]         f_disp;
    logic [FCH-1:0]     f_pulse;
    logic [FCH-1:0]     f_ovf;
    logic [FCH*FCW-1:0] f_flat;

    ext_edge_counter_multi #(
        .CHANNELS   (FCH),
        .CNT_WIDTH  (FCW),
        .FILTER_LEN (3)
    ) u_filt (
        .CLK_IN       (CLK_IN),
        .RST_IN       (RST_IN),
        .sig_i        (f_sig),
        .edge_mode_i  (f_mode),
        .clear_i      (f_clr),
        .sel_i        (f_sel),
        .disp_o       (f_disp),
        .edge_pulse_o (f_pulse),
        .overflow_o   (f_ovf),
        .count_flat_o (f_flat)
    );

    // ---------------- saturating, 8-bit, 1 channel ----------------
    logic [0:0] s_sig;
    logic [0:0] s_clr;
    logic [1:0] s_mode;
    logic [0:0] s_sel;
    logic [7:0] s_disp;
    logic [0:0] s_pulse;
    logic [0:0] s_ovf;
    logic [7:0] s_flat;

    ext_edge_counter_multi #(
        .CHANNELS  (1),
        .CNT_WIDTH (8),
        .SATURATE  (1)
    ) u_sat (
        .CLK_IN       (CLK_IN),
        .RST_IN       (RST_IN),
        .sig_i        (s_sig),
        .edge_mode_i  (s_mode),
        .clear_i      (s_clr),
        .sel_i        (s_sel),
        .disp_o       (s_disp),
        .edge_pulse_o (s_pulse),
        .overflow_o   (s_ovf),
        .count_flat_o (s_flat)
    );

    // ---------------- scoreboard ----------------
    int checks;
    int failures;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected cycle numbers of channel-0 pulses while tracking is on.
    logic [31:0] exp_q [$];
    logic        track_en;
    int          seen [CH];
    int          f_seen [FCH];
    int          s_seen;

    always @(negedge CLK_IN) begin
        if (!RST_IN) begin
            for (int i = 0; i < CH; i++)  if (epulse[i])  seen[i]++;
            for (int i = 0; i < FCH; i++) if (f_pulse[i]) f_seen[i]++;
            if (s_pulse[0]) s_seen++;
            if (track_en && epulse[0]) begin
                if (exp_q.size() == 0) check("pulse0_unexpected_cycle", 64'(cyc), 64'd0);
                else                   check("pulse0_timing", 64'(cyc), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    // A level driven at the negedge with cycle count c is sampled at edge
    // c+1 and pulses after edge c+3 with the default pipeline.
    task automatic drive_pulses(input int ch, input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            sig[ch] = 1'b1;
            if (track_en) exp_q.push_back(cyc + 3);
            tick(hi);
            sig[ch] = 1'b0;
            tick(lo);
        end
    endtask

    task automatic f_drive(input int ch, input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            f_sig[ch] = 1'b1;
            tick(hi);
            f_sig[ch] = 1'b0;
            tick(lo);
        end
    endtask

    task automatic s_drive(input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            s_sig[0] = 1'b1;
            tick(hi);
            s_sig[0] = 1'b0;
            tick(lo);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         pulses;
        int         hi;
        int         lo;
        int         exp_cnt;
        int         exp_seen;
    } vec_t;

    vec_t vecs [6];
    int   exp_cnt [CH];

    initial begin
        checks   = 0;
        failures = 0;
        track_en = 1'b0;
        s_seen   = 0;
        for (int i = 0; i < CH; i++)  begin seen[i] = 0; exp_cnt[i] = 0; end
        for (int i = 0; i < FCH; i++) f_seen[i] = 0;
        sig = '0; clr = '0; mode = 2'b01; sel = 2'd0;
        f_sig = '0; f_clr = '0; f_mode = 2'b01; f_sel = 2'd0;
        s_sig = '0; s_clr = '0; s_mode = 2'b01; s_sel = 1'b0;

        //                  ch  mode   n  hi  lo  cnt seen
        vecs[0] = '{0, 2'b01, 5, 10, 10, 5, 5};
        vecs[1] = '{2, 2'b11, 3, 10, 10, 6, 6};
        vecs[2] = '{2, 2'b10, 3, 10, 10, 9, 3};
        vecs[3] = '{2, 2'b00, 3, 10, 10, 9, 0};
        vecs[4] = '{1, 2'b01, 2,  2,  2, 2, 2};
        vecs[5] = '{3, 2'b11, 4,  2,  3, 8, 8};

        // ---- reset state ----
        RST_IN = 1'b1;
        tick(3);
        check("rst_count",   flat,   64'd0);
        check("rst_disp",    disp,   64'd0);
        check("rst_pulse",   epulse, 64'd0);
        check("rst_ovf",     ovf,    64'd0);
        check("rst_f_count", f_flat, 64'd0);
        check("rst_s_count", s_flat, 64'd0);
        RST_IN = 1'b0;
        tick(2);

        // ---- table-driven edge counting on the default instance ----
        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].mode;
            for (int i = 0; i < CH; i++) seen[i] = 0;
            track_en = (v == 0);
            tick(1);
            drive_pulses(vecs[v].ch, vecs[v].pulses, vecs[v].hi, vecs[v].lo);
            tick(4);
            track_en = 1'b0;
            exp_cnt[vecs[v].ch] = vecs[v].exp_cnt;
            for (int i = 0; i < CH; i++)
                check($sformatf("vec%0d_count%0d", v, i), flat[i*CW +: CW], exp_cnt[i]);
            check($sformatf("vec%0d_pulses", v), seen[vecs[v].ch], vecs[v].exp_seen);
        end
        check("pulse0_all_seen", exp_q.size(), 64'd0);
        check("no_overflow", ovf, 64'd0);

        // ---- mode changes while the input is held high ----
        mode = 2'b01;
        for (int i = 0; i < CH; i++) seen[i] = 0;
        sig[1] = 1'b1; tick(6);
        mode = 2'b10; tick(3);
        mode = 2'b11; tick(3);
        mode = 2'b00; tick(3);
        mode = 2'b01; tick(3);
        mode = 2'b00; sig[1] = 1'b0; tick(6);
        exp_cnt[1] = 3;
        check("modesw_count1", flat[1*CW +: CW], exp_cnt[1]);
        check("modesw_pulses", seen[1], 64'd1);

        // ---- simultaneous edges on all channels ----
        mode = 2'b01;
        tick(1);
        sig = 4'hF;
        tick(2); check("simul_before", epulse, 64'h0);
        tick(1); check("simul_pulse",  epulse, 64'hF);
        tick(1); check("simul_single", epulse, 64'h0);
        sig = 4'h0;
        tick(6);
        for (int i = 0; i < CH; i++) begin
            exp_cnt[i] = exp_cnt[i] + 1;
            check($sformatf("simul_count%0d", i), flat[i*CW +: CW], exp_cnt[i]);
        end

        // ---- per-channel clear, then preload 0x12AB for the display ----
        clr[0] = 1'b1; tick(1); clr[0] = 1'b0; tick(1);
        exp_cnt[0] = 0;
        check("clear_count0", flat[0 +: CW], 64'd0);
        check("clear_keeps2", flat[2*CW +: CW], exp_cnt[2]);
        drive_pulses(0, 16'h12AB, 2, 2);
        tick(4);
        check("preload_count0", flat[0 +: CW], 64'h12AB);
        sel = 2'd1; tick(2);
        check("disp_sel1", disp, 64'h00);
        sel = 2'd0;
        check("disp_latency_old", disp, 64'h00);
        tick(1);
        check("disp_sel0", disp, 64'h12);

        // ---- glitch filter ----
        f_sig[0] = 1'b1; tick(1); f_sig[0] = 1'b0; tick(10);
        f_sig[0] = 1'b1; tick(2); f_sig[0] = 1'b0; tick(10);
        check("filt_glitch_count", f_flat[0 +: FCW], 64'd0);
        check("filt_glitch_pulses", f_seen[0], 64'd0);
        f_sig[0] = 1'b1; tick(3); f_sig[0] = 1'b0; tick(2);
        check("filt_lat_early", f_flat[0 +: FCW], 64'd0);
        tick(1);
        check("filt_lat_count", f_flat[0 +: FCW], 64'd1);
        check("filt_lat_pulse", f_pulse, 64'b001);
        tick(10);
        check("filt_disp_sel0", f_disp, 64'h01);
        f_sel = 2'd3; tick(1);
        check("filt_disp_oor", f_disp, 64'h00);

        // ---- wrap and sticky overflow on u_filt channel 1 ----
        f_drive(1, 255, 4, 4); tick(8);
        check("wrap_255_count", f_flat[1*FCW +: FCW], 64'd255);
        check("wrap_255_ovf",   f_ovf[1], 64'd0);
        f_drive(1, 1, 4, 4); tick(8);
        check("wrap_256_count", f_flat[1*FCW +: FCW], 64'd0);
        check("wrap_256_ovf",   f_ovf[1], 64'd1);
        f_drive(1, 1, 4, 4); tick(8);
        check("wrap_257_count", f_flat[1*FCW +: FCW], 64'd1);
        check("wrap_sticky_ovf", f_ovf[1], 64'd1);
        // Clear lands on the same edge that would register the pulse.
        f_sig[1] = 1'b1; tick(4); f_sig[1] = 1'b0; tick(1);
        f_clr[1] = 1'b1; tick(1); f_clr[1] = 1'b0;
        check("clr_edge_pulse", f_pulse[1], 64'd0);
        check("clr_edge_count", f_flat[1*FCW +: FCW], 64'd0);
        check("clr_edge_ovf",   f_ovf[1], 64'd0);
        tick(10);
        check("clr_edge_after", f_flat[1*FCW +: FCW], 64'd0);
        check("clr_indep_ch0",  f_flat[0 +: FCW], 64'd1);

        // ---- saturation ----
        s_drive(255, 2, 2); tick(4);
        check("sat_255_count", s_flat, 64'd255);
        check("sat_255_ovf",   s_ovf,  64'd0);
        s_drive(45, 2, 2); tick(4);
        check("sat_300_count", s_flat, 64'd255);
        check("sat_300_ovf",   s_ovf,  64'd1);
        check("sat_pulses",    s_seen, 64'd300);
        check("sat_disp",      s_disp, 64'hFF);
        s_sel = 1'b1; tick(1);
        check("sat_disp_oor",  s_disp, 64'h00);

        // ---- asynchronous reset mid-run, release with sig[1] high ----
        @(posedge CLK_IN);
        #2;
        RST_IN = 1'b1;
        #1;
        check("arst_count",   flat,   64'd0);
        check("arst_disp",    disp,   64'd0);
        check("arst_f_count", f_flat, 64'd0);
        check("arst_s_ovf",   s_ovf,  64'd0);
        check("arst_s_count", s_flat, 64'd0);
        sig[1] = 1'b1;
        tick(3);
        check("arst_held", flat, 64'd0);
        RST_IN = 1'b0;
        tick(2);
        check("release_early", flat[1*CW +: CW], 64'd0);
        tick(1);
        check("release_count1", flat[1*CW +: CW], 64'd1);
        check("release_count0", flat[0 +: CW], 64'd0);
        sig[1] = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
